// File: rtl/panel_io_ctrl.sv
// Board-panel controller: synchronises and debounces active-low buttons into levels and sticky
// press events, and drives active-low LEDs in off/on/blink/PWM-dim modes chosen by the host.
module panel_io_ctrl #(
  parameter int N_BTN             = 4,
  parameter int N_LED             = 8,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int BLINK_HALF_PERIOD = 4800000,
  parameter int PWM_BITS          = 8
) (
  input  logic                 ti_clk,
  input  logic                 reset,
  input  logic [N_BTN-1:0]     button_n,
  output logic [N_LED-1:0]     led_n,
  input  logic [2*N_LED-1:0]   led_mode,
  input  logic [PWM_BITS-1:0]  led_duty,
  output logic [N_BTN-1:0]     btn_level,
  output logic [N_BTN-1:0]     btn_event,
  input  logic [N_BTN-1:0]     event_clr,
  output logic                 event_any
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int BL_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_PERIOD - 1);

  logic [N_BTN-1:0]    sync_meta;
  logic [N_BTN-1:0]    btn_sync;
  logic [N_BTN-1:0]    level_d;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [N_LED-1:0]    led_on;

  // Two-flop synchroniser; inverted so downstream logic sees 1 = pressed.
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      btn_sync  <= '0;
    end else begin
      sync_meta <= ~button_n;
      btn_sync  <= sync_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            level;

      // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (btn_sync[gi] == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt   <= '0;
          level <= btn_sync[gi];
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end

      assign btn_level[gi] = level;
    end
  endgenerate

  // Set has priority over clear so a press coinciding with a host clear is not lost.
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      level_d   <= '0;
      btn_event <= '0;
      event_any <= 1'b0;
    end else begin
      level_d   <= btn_level;
      btn_event <= (btn_event & ~event_clr) | (btn_level & ~level_d);
      event_any <= |btn_event;
    end
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (blink_cnt == BL_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
    end
  end

  assign pwm_on = (pwm_cnt < led_duty);

  generate
    for (gi = 0; gi < N_LED; gi++) begin : g_led
      logic [1:0] mode;
      assign mode       = led_mode[2*gi +: 2];
      assign led_on[gi] = (mode == 2'b01) ||
                          ((mode == 2'b10) && blink_phase) ||
                          ((mode == 2'b11) && pwm_on);
    end
  endgenerate

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      led_n <= '1;
    end else begin
      led_n <= ~led_on;
    end
  end

endmodule

// File: tb/tb_panel_io_ctrl.sv
// Self-checking bench for panel_io_ctrl: table vectors, hand-written corner sequences and
// randomized stimulus compared every cycle against a cycle-count based reference model.
module tb_panel_io_ctrl;
  localparam int N_BTN = 4;
  localparam int N_LED = 8;
  localparam int DEB   = 4;
  localparam int HALF  = 3;
  localparam int PB    = 3;

  logic                ti_clk = 1'b0;
  logic                reset;
  logic [N_BTN-1:0]    button_n;
  logic [N_LED-1:0]    led_n;
  logic [2*N_LED-1:0]  led_mode;
  logic [PB-1:0]       led_duty;
  logic [N_BTN-1:0]    btn_level;
  logic [N_BTN-1:0]    btn_event;
  logic [N_BTN-1:0]    event_clr;
  logic                event_any;

  int vectors = 0;
  int miscompares = 0;

  always #5 ti_clk = ~ti_clk;

  panel_io_ctrl #(
    .N_BTN(N_BTN), .N_LED(N_LED), .DEBOUNCE_CYCLES(DEB),
    .BLINK_HALF_PERIOD(HALF), .PWM_BITS(PB)
  ) dut (
    .ti_clk(ti_clk), .reset(reset), .button_n(button_n), .led_n(led_n),
    .led_mode(led_mode), .led_duty(led_duty), .btn_level(btn_level),
    .btn_event(btn_event), .event_clr(event_clr), .event_any(event_any)
  );

  // Reference model: button history, run lengths of disagreement, and LED timebases derived
  // arithmetically from the number of clock edges since reset release.
  logic [N_BTN-1:0] m_hist1, m_hist2, m_level, m_rise, m_evt;
  logic             m_any;
  logic [N_LED-1:0] m_led;
  int               m_run[N_BTN];
  int               m_n;

  task automatic model_reset();
    m_hist1 = '0; m_hist2 = '0; m_level = '0; m_rise = '0; m_evt = '0;
    m_any = 1'b0; m_led = '1; m_n = 0;
    for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [N_LED-1:0] on;
    logic [N_BTN-1:0] rose;
    int ph, pc;
    ph = (m_n / HALF) % 2;
    pc = m_n % (1 << PB);
    for (int i = 0; i < N_LED; i++) begin
      case (led_mode[2*i +: 2])
        2'b00:   on[i] = 1'b0;
        2'b01:   on[i] = 1'b1;
        2'b10:   on[i] = (ph == 1);
        default: on[i] = (pc < int'(led_duty));
      endcase
    end
    m_led = ~on;
    m_any = |m_evt;
    m_evt = (m_evt & ~event_clr) | m_rise;
    rose = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (m_hist2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = m_hist2[i];
          m_run[i] = 0;
          rose[i] = m_level[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rise = rose;
    m_hist2 = m_hist1;
    m_hist1 = ~button_n;
    m_n++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ti_clk);
    if (reset) model_reset();
    else model_step();
    @(negedge ti_clk);
    chk("model", {15'd0, led_n, btn_level, btn_event, event_any},
        {15'd0, m_led, m_level, m_evt, m_any});
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_led", {24'd0, led_n}, 32'hFF);
    chk("async_reset_lvl", {28'd0, btn_level}, 32'h0);
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] mode;
    logic [2:0]  duty;
    logic [7:0]  exp_led;
  } led_vec_t;

  led_vec_t tbl[6];
  logic [7:0] blink_exp;
  logic [7:0] pwm3_exp;
  int hold[N_BTN];

  initial begin
    tbl[0] = '{mode: 16'h0000, duty: 3'd0, exp_led: 8'hFF};
    tbl[1] = '{mode: 16'h5555, duty: 3'd0, exp_led: 8'h00};
    tbl[2] = '{mode: 16'h5500, duty: 3'd5, exp_led: 8'h0F};
    tbl[3] = '{mode: 16'h0055, duty: 3'd2, exp_led: 8'hF0};
    tbl[4] = '{mode: 16'h4411, duty: 3'd7, exp_led: 8'h5A};
    tbl[5] = '{mode: 16'hD7D7, duty: 3'd0, exp_led: 8'h99};
    blink_exp = 8'hC7;
    pwm3_exp  = 8'hF8;

    button_n = '1; event_clr = '0; led_mode = 16'h5555; led_duty = '0; reset = 1'b1;
    @(negedge ti_clk);

    // Reset with all LEDs in "on" mode: dark during reset, lit after the first edge.
    apply_reset(3);
    tick();
    chk("post_reset_led", {24'd0, led_n}, 32'h00);

    for (int v = 0; v < 6; v++) begin
      led_mode = tbl[v].mode;
      led_duty = tbl[v].duty;
      tick();
      chk($sformatf("table_%0d", v), {24'd0, led_n}, {24'd0, tbl[v].exp_led});
    end

    // Clean press on button 0: level after 6 edges, event one later, event_any one after that.
    led_mode = '0;
    button_n[0] = 1'b0;
    repeat (5) tick();
    chk("b0_level_early", {31'd0, btn_level[0]}, 32'd0);
    tick();
    chk("b0_level", {31'd0, btn_level[0]}, 32'd1);
    chk("b0_event_early", {31'd0, btn_event[0]}, 32'd0);
    tick();
    chk("b0_event", {31'd0, btn_event[0]}, 32'd1);
    chk("any_early", {31'd0, event_any}, 32'd0);
    tick();
    chk("any", {31'd0, event_any}, 32'd1);
    repeat (2) tick();
    event_clr[0] = 1'b1;
    tick();
    event_clr[0] = 1'b0;
    chk("b0_cleared", {31'd0, btn_event[0]}, 32'd0);
    tick();
    chk("any_cleared", {31'd0, event_any}, 32'd0);
    button_n[0] = 1'b1;
    repeat (8) tick();
    chk("b0_release_no_event", {28'd0, btn_level, btn_event}, 32'd0);

    // Bouncy button 1: runs of 3 never reach the debounce threshold.
    button_n[1] = 1'b0; repeat (3) tick();
    button_n[1] = 1'b1; tick();
    button_n[1] = 1'b0; repeat (3) tick();
    button_n[1] = 1'b1; repeat (8) tick();
    chk("b1_glitch_level", {31'd0, btn_level[1]}, 32'd0);
    chk("b1_glitch_event", {31'd0, btn_event[1]}, 32'd0);

    // Button 2: second press lands on the same edge as a host clear; the set must win.
    button_n[2] = 1'b0; repeat (7) tick();
    chk("b2_first_event", {31'd0, btn_event[2]}, 32'd1);
    event_clr[2] = 1'b1; tick(); event_clr[2] = 1'b0;
    chk("b2_first_clear", {31'd0, btn_event[2]}, 32'd0);
    button_n[2] = 1'b1; repeat (8) tick();
    button_n[2] = 1'b0; repeat (6) tick();
    chk("b2_second_level", {31'd0, btn_level[2]}, 32'd1);
    event_clr[2] = 1'b1; tick(); event_clr[2] = 1'b0;
    chk("b2_set_wins", {31'd0, btn_event[2]}, 32'd1);
    button_n[2] = 1'b1; repeat (8) tick();

    // Blink on LED0 and PWM duty 3 on LED1 from a fresh reset, then duty 0.
    led_mode = 16'h000E;
    led_duty = 3'd3;
    apply_reset(2);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("blink_%0d", k), {31'd0, led_n[0]}, {31'd0, blink_exp[k]});
      chk($sformatf("pwm3_%0d", k), {31'd0, led_n[1]}, {31'd0, pwm3_exp[k]});
    end
    led_duty = 3'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("pwm0_%0d", k), {31'd0, led_n[1]}, 32'd1);
    end

    // Reset mid-debounce (counter at 2) and mid-blink: everything restarts cleanly.
    button_n[3] = 1'b0;
    repeat (4) tick();
    button_n = '1;
    apply_reset(2);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rst_blink_%0d", k), {31'd0, led_n[0]}, {31'd0, blink_exp[k]});
      chk($sformatf("rst_btn_%0d", k), {28'd0, btn_level, btn_event}, 32'd0);
    end

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < N_BTN; i++) hold[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (hold[i] == 0) begin
          button_n[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 8);
        end
        hold[i]--;
      end
      event_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
      if (c % 25 == 0) led_mode = 16'($urandom);
      if (c % 7 == 0) led_duty = 3'($urandom);
      if (c == 300) begin
        apply_reset(2);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/panel_io_ctrl.md
Name: panel_io_ctrl

Overview:
Parametrised board-panel controller between FrontPanel wire endpoints and the on-board buttons/LEDs. Synchronises and debounces N_BTN active-low buttons, then reports debounced levels and sticky press events for a Wire Out. Drives N_LED active-low LEDs. Each LED has a host-selected mode from a Wire In: off, on, blink or PWM dim.

Parameters:
N_BTN, 4, number of buttons (1..16)
N_LED, 8, number of LEDs (1..16)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a button change (>=2)
BLINK_HALF_PERIOD, 4800000, ti_clk cycles per blink phase (>=1)
PWM_BITS, 8, PWM counter and duty width

Ports:
ti_clk  in  1  host-interface clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
button_n  in  N_BTN  raw board buttons, active-low, asynchronous
led_n  out  N_LED  board LEDs, active-low, registered
led_mode  in  2*N_LED  per-LED mode, bits [2i+1:2i] for LED i; 00 off, 01 on, 10 blink, 11 PWM
led_duty  in  PWM_BITS  shared PWM duty
btn_level  out  N_BTN  debounced pressed state, 1 = pressed
btn_event  out  N_BTN  sticky press-event flags
event_clr  in  N_BTN  write-1-to-clear pulse per event bit
event_any  out  1  OR of btn_event

Behaviour:
- Reset (async assert, sync-to-ti_clk release handled upstream) values:
  - sync FFs 0 (released), btn_level 0, debounce counters 0, btn_event 0, event_any 0
  - blink counter 0, blink_phase 0, pwm counter 0
  - led_n all 1 (LEDs dark)
- Synchroniser: two-FF chain per button on ~button_n, giving btn_sync (1 = pressed).
- Debounce, per button, counter width clog2(DEBOUNCE_CYCLES):
  - btn_sync == btn_level: counter <= 0.
  - Otherwise counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and still differing: btn_level <= btn_sync, counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count; btn_level never changes.
  - Latency from a clean button_n edge to the btn_level change: 2 + DEBOUNCE_CYCLES cycles.
- Events:
  - Debounced rising edge of btn_level[i] sets btn_event[i] on the cycle after btn_level rises.
  - event_clr[i] clears the bit on the next cycle.
  - Set and clear in the same cycle: set wins, so no event is lost.
  - Release edges generate no event.
  - event_any is registered: one cycle after btn_event.
- Blink timebase:
  - Counter runs 0..BLINK_HALF_PERIOD-1 and wraps to 0.
  - blink_phase toggles on each wrap.
  - Shared by all LEDs, so blinking LEDs are phase-aligned.
- PWM:
  - Free-running PWM_BITS counter, wraps at 2^PWM_BITS-1 -> 0.
  - pwm_on = (pwm_cnt < led_duty), unsigned.
  - Duty 0 gives always off; duty 2^PWM_BITS-1 gives on for all but one count.
- LED output: led_n[i] <= ~on_i, registered, where on_i by mode is:
  - 00: 0
  - 01: 1
  - 10: blink_phase
  - 11: pwm_on
- Mode or duty change is visible on led_n one cycle later. No glitch beyond normal mode semantics.
- Reset mid-operation clears all state immediately. LEDs go dark and pending events are lost.
- Every counter wraps or saturates within its width; none overflows silently.

Test Plan:
(All with DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=3, PWM_BITS=3, N_BTN=4, N_LED=8.)
1. Reset while led_mode=all 01 -> led_n=8'hFF during reset; 8'h00 one cycle after the first post-reset edge.
2. button_n[0] held 0 from cycle 10 -> btn_level[0]=1 at cycle 16; btn_event[0]=1 at 17; event_any=1 at 18. Pulse event_clr[0] at 20 -> btn_event[0]=0 at 21.
3. button_n[1] low for 3 cycles, high for 1, low for 3 -> btn_level[1] stays 0 and btn_event[1] stays 0.
4. Second debounced press on button 2 asserted on the same cycle event_clr[2]=1 -> btn_event[2] remains 1.
5. led_mode LED0=10 -> led_n[0] toggles every 3 cycles (period 6). LED1=11 with led_duty=3 -> led_n[1] low 3 of every 8 cycles. led_duty=0 -> led_n[1] constant 1.
6. Assert reset mid-debounce (counter=2) and mid-blink -> after release, btn_level=0, no event, blink restarts from phase 0.
